// File: rtl/alu_arbiter.sv
`default_nettype none
// =============================================================================
// alu_arbiter : two-port request arbiter sharing one ALU, in-order responses
// Rev 1.0
// =============================================================================
module alu_arbiter #(
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ReqValidA,
   output logic        ReqReadyA,
   input  logic [31:0] ReqOp1A,
   input  logic [31:0] ReqOp2A,
   input  logic [3:0]  ReqCtrlA,
   input  logic        ReqValidB,
   output logic        ReqReadyB,
   input  logic [31:0] ReqOp1B,
   input  logic [31:0] ReqOp2B,
   input  logic [3:0]  ReqCtrlB,
   output logic        RespValidA,
   input  logic        RespReadyA,
   output logic [31:0] RespDataA,
   output logic        RespValidB,
   input  logic        RespReadyB,
   output logic [31:0] RespDataB,
   output logic [31:0] Operand1,
   output logic [31:0] Operand2,
   output logic [3:0]  AluContrl,
   input  logic [31:0] AluOut
);

   localparam logic c_port_a = 1'b0;
   localparam logic c_port_b = 1'b1;

   logic        s1_valid_q, s1_valid_d;
   logic        s1_owner_q, s1_owner_d;
   logic [31:0] s1_op1_q, s1_op1_d;
   logic [31:0] s1_op2_q, s1_op2_d;
   logic [3:0]  s1_ctrl_q, s1_ctrl_d;
   logic        last_q, last_d;

   logic [1:0]        req_valid;
   logic [1:0]        resp_ready;
   logic [1:0]        resp_valid;
   logic [1:0]        push;
   logic [1:0]        pop;
   logic [1:0]        elig;
   logic [1:0]        grant;
   logic [1:0][1:0]   resp_cnt;
   logic [1:0][31:0]  resp_head;
   logic [2:0]        out_cnt_a;
   logic [2:0]        out_cnt_b;

   assign req_valid  = {ReqValidB, ReqValidA};
   assign resp_ready = {RespReadyB, RespReadyA};

   always_comb begin
      resp_valid[0] = (resp_cnt[0] != 2'd0);
      resp_valid[1] = (resp_cnt[1] != 2'd0);
      pop           = resp_valid & resp_ready;
      push[0]       = s1_valid_q && (s1_owner_q == c_port_a);
      push[1]       = s1_valid_q && (s1_owner_q == c_port_b);
   end

   // Outstanding work per port counts the in-flight S1 entry; a same-cycle pop frees a slot.
   always_comb begin
      out_cnt_a = {1'b0, resp_cnt[0]} + {2'b00, push[0]};
      out_cnt_b = {1'b0, resp_cnt[1]} + {2'b00, push[1]};
      elig[0]   = rst_n && req_valid[0] && ((out_cnt_a - {2'b00, pop[0]}) < 3'd2);
      elig[1]   = rst_n && req_valid[1] && ((out_cnt_b - {2'b00, pop[1]}) < 3'd2);
   end

   always_comb begin
      grant = 2'b00;
      if (FIXED_PRIO != 0) begin
         if (elig[0]) begin
            grant[0] = 1'b1;
         end else if (elig[1]) begin
            grant[1] = 1'b1;
         end
      end else begin
         if (elig[0] && elig[1]) begin
            if (last_q == c_port_b) begin
               grant[0] = 1'b1;
            end else begin
               grant[1] = 1'b1;
            end
         end else if (elig[0]) begin
            grant[0] = 1'b1;
         end else if (elig[1]) begin
            grant[1] = 1'b1;
         end
      end
   end

   always_comb begin
      last_d = last_q;
      if (grant[0]) begin
         last_d = c_port_a;
      end else if (grant[1]) begin
         last_d = c_port_b;
      end
   end

   // S1 never holds: it loads the granted request or clears every cycle.
   always_comb begin
      s1_valid_d = |grant;
      s1_owner_d = grant[1] ? c_port_b : c_port_a;
      s1_op1_d   = '0;
      s1_op2_d   = '0;
      s1_ctrl_d  = '0;
      if (grant[0]) begin
         s1_op1_d  = ReqOp1A;
         s1_op2_d  = ReqOp2A;
         s1_ctrl_d = ReqCtrlA;
      end else if (grant[1]) begin
         s1_op1_d  = ReqOp1B;
         s1_op2_d  = ReqOp2B;
         s1_ctrl_d = ReqCtrlB;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_owner_q <= c_port_a;
         s1_op1_q   <= '0;
         s1_op2_q   <= '0;
         s1_ctrl_q  <= '0;
         last_q     <= c_port_b;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_owner_q <= s1_owner_d;
         s1_op1_q   <= s1_op1_d;
         s1_op2_q   <= s1_op2_d;
         s1_ctrl_q  <= s1_ctrl_d;
         last_q     <= last_d;
      end
   end

   for (genvar p = 0; p < 2; p++) begin : g_resp_fifo
      logic [31:0] mem_q [2];
      logic [31:0] mem_d [2];
      logic        wr_ptr_q, wr_ptr_d;
      logic        rd_ptr_q, rd_ptr_d;
      logic [1:0]  cnt_q, cnt_d;

      always_comb begin
         mem_d    = mem_q;
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = rd_ptr_q;
         cnt_d    = cnt_q;
         if (push[p]) begin
            mem_d[wr_ptr_q] = AluOut;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (pop[p]) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         case ({push[p], pop[p]})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
         endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
         end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
         end
      end

      assign resp_cnt[p]  = cnt_q;
      assign resp_head[p] = mem_q[rd_ptr_q];

      a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
         !(push[p] && (cnt_q == 2'd2)));
   end

   assign ReqReadyA  = grant[0];
   assign ReqReadyB  = grant[1];
   assign RespValidA = resp_valid[0];
   assign RespValidB = resp_valid[1];
   assign RespDataA  = resp_valid[0] ? resp_head[0] : 32'd0;
   assign RespDataB  = resp_valid[1] ? resp_head[1] : 32'd0;
   assign Operand1   = s1_valid_q ? s1_op1_q  : 32'd0;
   assign Operand2   = s1_valid_q ? s1_op2_q  : 32'd0;
   assign AluContrl  = s1_valid_q ? s1_ctrl_q : 4'd0;

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU instance between two requesters: port A (EX-stage integer path) and port B (auxiliary address/CSR unit). Each request carries two operands and an ALU control code. The block arbitrates one request per cycle into an issue register that drives the ALU, then captures the result into a per-requester 2-entry response FIFO. Each port sees a valid/ready request channel and a valid/ready response channel, and results on each port return strictly in request order.

## Interface
- FIXED_PRIO, default 0: selects the arbitration policy. 0 = round-robin, 1 = port A always wins.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- ReqValidA / ReqValidB  input  1  request present
- ReqReadyA / ReqReadyB  output  1  request accepted this cycle when both valid and ready are high
- ReqOp1A / ReqOp1B  input  32  operand 1
- ReqOp2A / ReqOp2B  input  32  operand 2
- ReqCtrlA / ReqCtrlB  input  4  ALU control code, Parameters.v encoding
- RespValidA / RespValidB  output  1  result available at the response FIFO head
- RespReadyA / RespReadyB  input  1  consumer pops the head this cycle when high with RespValid
- RespDataA / RespDataB  output  32  response FIFO head data
- Operand1 / Operand2  output  32  to the ALU, from the issue register
- AluContrl  output  4  to the ALU, from the issue register
- AluOut  input  32  from the ALU (combinational)

## Operation

**Issue register (S1)**
- Fields: valid, owner (A/B), op1, op2, ctrl.
- When valid, S1 drives Operand1, Operand2 and AluContrl.
- When invalid, those outputs are all zero.
- S1 never stalls. It is reloaded or cleared every cycle.

**Response FIFOs**
- One per port, depth 2, with 2-bit count.
- When S1 is valid, AluOut is pushed into the owner's FIFO at the next edge.

**Outstanding count**
- out_x = resp_count_x + (S1.valid && S1.owner == x).
- Port x is eligible when ReqValid_x is high and (out_x − pop_x) < 2, where pop_x = RespValid_x && RespReady_x.

**Arbitration**
- At most one grant per cycle.
- ReqReady_x is high only for the granted port. It is a combinational function of the valids, the counts, the pops and the pointer.
- FIXED_PRIO = 0:
  - 1-bit last pointer, reset value B, so A wins first.
  - If both ports are eligible, grant the port that is not last.
  - If only one port is eligible, grant it.
  - last updates to the granted port, and only on a grant.
- FIXED_PRIO = 1: grant A if eligible, otherwise B if eligible.

**Simultaneous push and pop on one FIFO**
- Count is unchanged.
- Ordering is preserved.
- Pushing into a full FIFO is unreachable by construction. An assertion checks it.

## Timing
- Reset values:
  - ReqReadyA/B = 0 while rst_n is low.
  - RespValidA/B = 0.
  - RespDataA/B = 0.
  - Operand1, Operand2, AluContrl = 0.
  - S1.valid = 0, FIFO counts = 0, last = B.
- Latency: request accepted at edge N → S1 valid in cycle N+1 → RespValid high in cycle N+2.
- Throughput: one accept per cycle total.
  - A single port with RespReady held high sustains one result per cycle.
- Backpressure:
  - With RespReady_x low, port x accepts at most 2 requests.
  - Both FIFO slots may be filled, or one slot plus S1.
  - ReqReady_x then stays low until a pop frees capacity.
  - A pop in cycle N makes port x eligible in cycle N itself, since pop_x is subtracted.
- Reset mid-operation (asynchronous):
  - S1 and both FIFOs are discarded.
  - No response is emitted for in-flight requests.
  - All outputs take their reset values immediately.
- Unknown ctrl codes are passed through unchecked. The result is whatever the ALU produces (0 for undefined codes).

## Test plan
1. **Reset.** Hold rst_n low with ReqValidA = 1.
   - ReqReadyA = 0, all outputs 0.
   - Release at edge N: ReqReadyA = 1 in cycle N.
2. **Single op, port A.** Op1 = 5, Op2 = 7, ctrl = ADD, RespReadyA = 1.
   - Operand1/2 = 5/7 one cycle after the accept.
   - RespValidA = 1 with RespDataA = 12 two cycles after the accept.
3. **Round-robin, FIXED_PRIO = 0.** Both ports valid continuously. A issues SUB 10−3; B issues SLL 1<<4. Both RespReady = 1.
   - Grants alternate A, B, A, B.
   - Responses: RespDataA = 7, RespDataB = 16, alternating each cycle.
4. **Fixed priority, FIXED_PRIO = 1.** Same stimulus as scenario 3.
   - B is never granted while A is eligible.
   - Drop ReqValidA → B is granted in that same cycle.
5. **Backpressure, port A.** RespReadyA = 0. A issues XOR ops 0xF0^0x0F, then 0xFF^0x01, then a third op.
   - The first two are accepted; the third sees ReqReadyA = 0.
   - Raise RespReadyA → pops 0xFF then 0xFE in order.
   - The third op is accepted in the first pop cycle.
   - Port B continues to be granted throughout.
6. **Reset mid-flight.** Pulse rst_n low while S1 is valid and RespCountB = 1.
   - RespValidB drops to 0 immediately.
   - After release, no stale result appears.
   - The next B request returns its correct result.
